// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register queue: opcode encoding and stored entry layout.
package instr_register_pkg;

  localparam int unsigned OP_WIDTH      = 32;
  localparam int unsigned DEFAULT_DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t                       opcode;
    logic signed [OP_WIDTH-1:0]    a;
    logic signed [OP_WIDTH-1:0]    b;
    logic signed [2*OP_WIDTH-1:0]  result;
    logic                          err;
  } entry_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU: sign-extends both operands to 2*OP_WIDTH and evaluates the opcode.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 32
) (
  input  logic [3:0]            opcode_i,
  input  logic [OP_WIDTH-1:0]   operand_a_i,
  input  logic [OP_WIDTH-1:0]   operand_b_i,
  output logic [2*OP_WIDTH-1:0] result_o,
  output logic                  err_o
);

  localparam int unsigned ResW = 2 * OP_WIDTH;

  logic signed [ResW-1:0] a_ext;
  logic signed [ResW-1:0] b_ext;
  logic                   b_zero;

  // Widening first keeps MULT exact and makes most-negative / -1 representable.
  assign a_ext  = {{OP_WIDTH{operand_a_i[OP_WIDTH-1]}}, operand_a_i};
  assign b_ext  = {{OP_WIDTH{operand_b_i[OP_WIDTH-1]}}, operand_b_i};
  assign b_zero = (operand_b_i == '0);

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (opcode_i)
      ZERO:  result_o = '0;
      PASSA: result_o = a_ext;
      PASSB: result_o = b_ext;
      ADD:   result_o = a_ext + b_ext;
      SUB:   result_o = a_ext - b_ext;
      MULT:  result_o = a_ext * b_ext;
      DIV: begin
        if (b_zero) err_o = 1'b1;
        else        result_o = a_ext / b_ext;
      end
      MOD: begin
        if (b_zero) err_o = 1'b1;
        else        result_o = a_ext % b_ext;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_register_queue.sv
// Circular instruction queue: results computed at write time, drained first-word-fall-through.
module instr_register_queue
  import instr_register_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 32,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [3:0]                 opcode_in,
  input  logic [OP_WIDTH-1:0]        operand_a_in,
  input  logic [OP_WIDTH-1:0]        operand_b_in,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [3:0]                 opcode_out,
  output logic [OP_WIDTH-1:0]        operand_a_out,
  output logic [OP_WIDTH-1:0]        operand_b_out,
  output logic [2*OP_WIDTH-1:0]      result_out,
  output logic                       err_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned ResW = 2 * OP_WIDTH;

  logic [3:0]          opcode_mem [DEPTH];
  logic [OP_WIDTH-1:0] a_mem      [DEPTH];
  logic [OP_WIDTH-1:0] b_mem      [DEPTH];
  logic [ResW-1:0]     result_mem [DEPTH];
  logic                err_mem    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            wr_en;
  logic            rd_en;
  logic [ResW-1:0] alu_result;
  logic            alu_err;

  instr_alu #(
    .OP_WIDTH(OP_WIDTH)
  ) u_alu (
    .opcode_i   (opcode_in),
    .operand_a_i(operand_a_in),
    .operand_b_i(operand_b_in),
    .result_o   (alu_result),
    .err_o      (alu_err)
  );

  assign wr_ready = (count_q != CntW'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign wr_en    = wr_valid && wr_ready;
  assign rd_en    = rd_valid && rd_ready;
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_valid & ~wr_ready);
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not cleared; reset and flush only suppress the write.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_en) begin
      opcode_mem[wr_ptr_q] <= opcode_in;
      a_mem[wr_ptr_q]      <= operand_a_in;
      b_mem[wr_ptr_q]      <= operand_b_in;
      result_mem[wr_ptr_q] <= alu_result;
      err_mem[wr_ptr_q]    <= alu_err;
    end
  end

  always_comb begin
    opcode_out    = '0;
    operand_a_out = '0;
    operand_b_out = '0;
    result_out    = '0;
    err_out       = 1'b0;
    if (rd_valid) begin
      opcode_out    = opcode_mem[rd_ptr_q];
      operand_a_out = a_mem[rd_ptr_q];
      operand_b_out = b_mem[rd_ptr_q];
      result_out    = result_mem[rd_ptr_q];
      err_out       = err_mem[rd_ptr_q];
    end
  end

endmodule

// File: doc/instr_register_queue.md
Name: instr_register_queue

Overview:
Parametrised successor to the instruction register. It accepts instructions (opcode plus two signed operands) through a valid/ready write port and computes each result at write time. Each instruction, its result and an error flag are stored in a circular queue of DEPTH entries and drained in order through a valid/ready read port. Per-entry pointers are replaced by internal auto-incrementing pointers, and the block adds a flush, an occupancy count and a sticky overflow flag. It sits between the test-side driver and the checker in the lab01 bench, in place of the fixed-size register.

Parameters:
OP_WIDTH, 32, width of each signed operand; result width is 2*OP_WIDTH
DEPTH, 32, number of queue entries; power of two, >= 2

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous queue clear
wr_valid  input  1  write request
wr_ready  output  1  queue can accept a write
opcode_in  input  4  opcode_t
operand_a_in  input  OP_WIDTH  signed operand A
operand_b_in  input  OP_WIDTH  signed operand B
rd_valid  output  1  head entry available
rd_ready  input  1  consumer takes head entry
opcode_out  output  4  head opcode
operand_a_out  output  OP_WIDTH  head operand A
operand_b_out  output  OP_WIDTH  head operand B
result_out  output  2*OP_WIDTH  head result, signed
err_out  output  1  head entry error flag
count  output  $clog2(DEPTH+1)  occupied entries
overflow  output  1  sticky: write attempted while full

Behaviour:
- Reset, and the single clock/reset pair: reset=1 sampled at a rising edge of clk. Effect: wr_ptr=0, rd_ptr=0, count=0, overflow=0. Resulting outputs: wr_ready=1, rd_valid=0, and opcode_out, operands, result_out and err_out all 0. Storage contents need not be cleared; outputs are forced to 0 while count=0.
- Reset mid-operation: all pending entries are discarded and no partial write survives.
- Write accept: wr_valid && wr_ready at an edge stores {opcode, a, b, result, err} at wr_ptr, then wr_ptr+1 (mod DEPTH) and count+1. wr_ready = (count != DEPTH), which is purely combinational from count.
- Read accept: rd_valid && rd_ready at an edge advances rd_ptr+1 (mod DEPTH) and count-1. rd_valid = (count != 0).
- Read data is first-word-fall-through: outputs show the entry at rd_ptr combinationally. An entry written at edge N is visible as rd_valid=1 after edge N, so write-to-read latency is 1 cycle.
- Simultaneous write and read: both are accepted and count is unchanged.
  - When full, wr_ready=0 even if a read happens in the same cycle; the write is not accepted.
  - When empty, no read can occur because rd_valid=0.
- Overflow: wr_valid=1 while count==DEPTH sets overflow=1. It stays set until reset or flush. The write is dropped with no state change.
- Flush: flush=1 at an edge sets pointers, count and overflow to 0. Flush takes priority over any write or read in that cycle, and accepts nothing.
- Priority: reset > flush > write/read.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Arithmetic: operands are sign-extended to 2*OP_WIDTH before the operation. Per opcode, with err=0 unless stated:
  - ZERO(0): result 0
  - PASSA(1): result a
  - PASSB(2): result b
  - ADD(3): a+b
  - SUB(4): a-b
  - MULT(5): full signed product
  - DIV(6): a/b, truncated toward zero
  - MOD(7): remainder, with the sign of the dividend
- Error cases:
  - DIV or MOD with b=0 gives result 0, err=1.
  - Opcodes 8..15 give result 0, err=1.
  - DIV of the most-negative value by -1 is exact in 2*OP_WIDTH, err=0.

Decomposition:
- instr_register_pkg, shared, holds:
  - opcode_t: 4-bit enum with the values above
  - entry_t: packed struct {opcode, a, b, result, err}, parametrised via localparam OP_WIDTH default 32
  - localparam DEFAULT_DEPTH=32
- Sub-module instr_alu: purely combinational; takes opcode, a and b, produces result and err. Reused by the bench's scoreboard model.
- The top module holds the storage array, pointers, count, flags and handshake logic.

Test Plan:
- Reset, then write ADD a=5, b=-7 -> after 1 cycle: rd_valid=1, result_out=-2, err_out=0, count=1; reading with rd_ready=1 -> count=0, rd_valid=0.
- Fill with DEPTH=32 writes of MULT a=i, b=3 -> wr_ready=0, count=32; an extra write -> overflow=1; drain all -> results 0,3,...,93 in order.
- With count=5, assert wr_valid and rd_ready together for 10 cycles -> count stays 5 and read order matches write order across the pointer wrap.
- DIV a=7, b=0 -> result 0, err=1; MOD a=-7, b=2 -> result -1; DIV a=-7, b=2 -> result -3; opcode 9 -> result 0, err=1.
- With count=8 and overflow=1, assert flush together with wr_valid -> next cycle count=0, overflow=0, rd_valid=0, and the write is not stored.
- Reset asserted mid-stream with count=12 -> next cycle count=0 and all outputs 0; a write one cycle after reset releases is read back correctly.
